eddsa_block_ctrl: RTL and testbench
===================================

EDDSA_BLOCK_CTRL -- requirements
Module: eddsa_block_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 64: host word width in bits.
REQ-002 SHALL have parameter WORDS, default 16: words per 1024-bit message block.
REQ-003 SHALL have parameter RST_CYCLES, default 2: core reset pulse length in cycles.
REQ-004 SHALL have parameter TIMEOUT, default 1048576: watchdog limit in cycles.
REQ-005 SHALL have port clk  in  1  the single clock; all logic rises on posedge clk.
REQ-006 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port cmd_start  in  1  starts an operation; sampled in IDLE only.
REQ-008 SHALL have port cmd_sel  in  2  operation code: 1 = sign, 2 = public key, 3 = verify; captured at start.
REQ-009 SHALL have port cmd_abort  in  1  aborts the operation and returns to IDLE.
REQ-010 SHALL have port word_in  in  WIDTH  host message word, MSB-first within the block.
REQ-011 SHALL have ports word_valid  in  1, word_last  in  1 and word_ready  out  1  as the host word handshake; word_last closes a short block.
REQ-012 SHALL have ports core_rst  out  1 (active-high), core_sel  out  2, core_message  out  1024 and core_block_valid  out  2  to drive the EdDSA core.
REQ-013 SHALL have ports core_block_ready  in  1, core_valid  in  1, core_error  in  1 and core_sig_pub  in  512  from the EdDSA core.
REQ-014 SHALL have ports busy  out  1, done  out  1 (one-cycle pulse), err  out  1, timeout  out  1 and result  out  512  toward the host.

Function
REQ-015 SHALL implement FSM IDLE -> CORE_RST -> RUN -> IDLE.
REQ-016 IDLE with cmd_start=1 SHALL capture cmd_sel into core_sel, clear err and timeout, and enter CORE_RST.
REQ-017 CORE_RST SHALL hold core_rst=1 for exactly RST_CYCLES cycles, clear the fill buffer and set core_block_valid=2'b00, then enter RUN.
REQ-018 In RUN, word_ready SHALL be 1 only while the fill buffer is not full; an accepted word SHALL be written at bits [1023-64*k -: 64] for k = 0..15.
REQ-019 The fill buffer SHALL become full on the 16th accepted word or on any accepted word with word_last=1; unwritten words SHALL read as zero.
REQ-020 The controller SHALL detect the rising edge of core_block_ready using a registered copy.
REQ-021 On a detected edge with a full buffer, the controller SHALL, in the next cycle, load core_message from the buffer, clear full and toggle core_block_valid.
REQ-022 The toggle sequence SHALL be 00 -> 10, 10 -> 01, 01 -> 10.
REQ-023 On a detected edge with the buffer not full, a pending-request flag SHALL be set; transfer SHALL occur on the cycle after the buffer becomes full; core_block_valid SHALL hold its value meanwhile.
REQ-024 Because word_ready=0 while full, a word accept and a buffer transfer SHALL never target the same slot; the host MAY fill the next block while the core consumes the current one.
REQ-025 A rising edge of core_valid in RUN SHALL capture core_sig_pub into result, pulse done for one cycle and enter IDLE.
REQ-026 A rising edge of core_error in RUN SHALL set err=1, pulse done and enter IDLE; result SHALL be unchanged.
REQ-027 The watchdog SHALL count cycles in RUN; reaching TIMEOUT SHALL set err=1 and timeout=1, pulse done, assert core_rst for RST_CYCLES cycles and enter IDLE.
REQ-028 cmd_abort in any non-IDLE state SHALL assert core_rst for RST_CYCLES cycles, clear the buffer and the pending flag, and enter IDLE without a done pulse; cmd_abort SHALL take priority over a same-cycle core_valid or core_error.
REQ-029 cmd_start SHALL be ignored outside IDLE.
REQ-030 busy SHALL be 1 in every state except IDLE.

Reset
REQ-031 While rst=0: state = IDLE; busy, done, err, timeout, word_ready, core_rst and the pending flag = 0; core_block_valid = 00; core_sel = 0; core_message, result, buffer and watchdog = 0.
REQ-032 Reset asserted mid-operation SHALL abandon the operation immediately, with no done pulse.

Verification
REQ-033 Sign: start with sel=1, then 3 core_block_ready edges with 16 words supplied per block -> core_block_valid goes 10, 01, 10; core_message equals each block bit-exact; core_valid -> result = core_sig_pub and done pulses once.
REQ-034 Short block: 10 words ending with word_last -> core_message[383:0] = 0 and word 0 is at [1023:960].
REQ-035 Stall: core_block_ready edge while the buffer holds 5 words -> core_block_valid unchanged until the 16th word, then toggles exactly one cycle later.
REQ-036 Error and timeout: core_error edge -> err=1, done pulse, result unchanged; with TIMEOUT=64 and no core response -> timeout=1, and core_rst high for 2 cycles.
REQ-037 Abort or reset mid-RUN: cmd_abort in the same cycle as core_valid -> no done pulse, IDLE, core_rst pulse; rst=0 mid-RUN -> every output at its REQ-031 value asynchronously.

Source files
------------

// File: rtl/eddsa_block_ctrl.sv
// Host-side controller for an EdDSA core: sequences core reset, packs host words into
// message blocks, hands blocks over on core_block_ready edges and collects the result.
module eddsa_block_ctrl #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned WORDS      = 16,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 1048576
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_start,
  input  logic [1:0]               cmd_sel,
  input  logic                     cmd_abort,
  input  logic [WIDTH-1:0]         word_in,
  input  logic                     word_valid,
  input  logic                     word_last,
  output logic                     word_ready,
  output logic                     core_rst,
  output logic [1:0]               core_sel,
  output logic [WIDTH*WORDS-1:0]   core_message,
  output logic [1:0]               core_block_valid,
  input  logic                     core_block_ready,
  input  logic                     core_valid,
  input  logic                     core_error,
  input  logic [511:0]             core_sig_pub,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     timeout,
  output logic [511:0]             result
);

  localparam int unsigned BLK = WIDTH * WORDS;
  localparam int unsigned AW  = $clog2(WORDS);
  localparam int unsigned RW  = $clog2(RST_CYCLES + 1);
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StCoreRst, StRun} state_e;

  state_e                       state_q, state_d;
  logic [1:0]                   core_sel_q, core_sel_d;
  logic                         core_rst_q, core_rst_d;
  logic [RW-1:0]                rcnt_q, rcnt_d;
  logic [WORDS-1:0][WIDTH-1:0]  buf_q, buf_d;
  logic [AW-1:0]                widx_q, widx_d;
  logic                         full_q, full_d;
  logic                         pend_q, pend_d;
  logic [1:0]                   cbv_q, cbv_d;
  logic [BLK-1:0]               msg_q, msg_d;
  logic [511:0]                 result_q, result_d;
  logic                         done_q, done_d;
  logic                         err_q, err_d;
  logic                         timeout_q, timeout_d;
  logic [TW-1:0]                wd_q, wd_d;
  logic                         rdy_q, val_q, cerr_q;
  logic                         rdy_edge, val_edge, cerr_edge;
  logic                         clear, pulse;

  assign rdy_edge  = core_block_ready & ~rdy_q;
  assign val_edge  = core_valid & ~val_q;
  assign cerr_edge = core_error & ~cerr_q;

  assign word_ready       = (state_q == StRun) && !full_q;
  assign busy             = (state_q != StIdle);
  assign core_rst         = core_rst_q;
  assign core_sel         = core_sel_q;
  assign core_message     = msg_q;
  assign core_block_valid = cbv_q;
  assign done             = done_q;
  assign err              = err_q;
  assign timeout          = timeout_q;
  assign result           = result_q;

  always_comb begin
    state_d    = state_q;
    core_sel_d = core_sel_q;
    core_rst_d = core_rst_q;
    rcnt_d     = rcnt_q;
    buf_d      = buf_q;
    widx_d     = widx_q;
    full_d     = full_q;
    pend_d     = pend_q;
    cbv_d      = cbv_q;
    msg_d      = msg_q;
    result_d   = result_q;
    done_d     = 1'b0;
    err_d      = err_q;
    timeout_d  = timeout_q;
    wd_d       = wd_q;
    clear      = 1'b0;
    pulse      = 1'b0;

    // Core reset pulse runs down independently so it can outlive an abort or timeout.
    if (core_rst_q) begin
      if (rcnt_q == '0) core_rst_d = 1'b0;
      else              rcnt_d     = rcnt_q - RW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_start) begin
          state_d    = StCoreRst;
          core_sel_d = cmd_sel;
          err_d      = 1'b0;
          timeout_d  = 1'b0;
          cbv_d      = 2'b00;
          wd_d       = '0;
          clear      = 1'b1;
          pulse      = 1'b1;
        end
      end
      StCoreRst: begin
        if (cmd_abort) begin
          state_d = StIdle;
          clear   = 1'b1;
          pulse   = 1'b1;
        end else if (core_rst_q && rcnt_q == '0) begin
          state_d = StRun;
        end
      end
      StRun: begin
        wd_d = wd_q + TW'(1);
        if (cmd_abort) begin
          state_d = StIdle;
          clear   = 1'b1;
          pulse   = 1'b1;
        end else if (cerr_edge) begin
          state_d = StIdle;
          err_d   = 1'b1;
          done_d  = 1'b1;
          clear   = 1'b1;
        end else if (val_edge) begin
          state_d  = StIdle;
          result_d = core_sig_pub;
          done_d   = 1'b1;
          clear    = 1'b1;
        end else if (wd_q == TW'(TIMEOUT - 1)) begin
          state_d   = StIdle;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          clear     = 1'b1;
          pulse     = 1'b1;
        end else begin
          // Word 0 lands in the most significant slot of the block.
          if (word_valid && word_ready) begin
            buf_d[AW'(WORDS - 1) - widx_q] = word_in;
            widx_d = widx_q + AW'(1);
            if (word_last || widx_q == AW'(WORDS - 1)) full_d = 1'b1;
          end
          if ((rdy_edge || pend_q) && full_q) begin
            msg_d  = buf_q;
            buf_d  = '0;
            widx_d = '0;
            full_d = 1'b0;
            pend_d = 1'b0;
            cbv_d  = (cbv_q == 2'b10) ? 2'b01 : 2'b10;
          end else if (rdy_edge) begin
            pend_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (clear) begin
      buf_d  = '0;
      widx_d = '0;
      full_d = 1'b0;
      pend_d = 1'b0;
    end
    if (pulse) begin
      core_rst_d = 1'b1;
      rcnt_d     = RW'(RST_CYCLES - 1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      core_sel_q <= '0;
      core_rst_q <= 1'b0;
      rcnt_q     <= '0;
      buf_q      <= '0;
      widx_q     <= '0;
      full_q     <= 1'b0;
      pend_q     <= 1'b0;
      cbv_q      <= 2'b00;
      msg_q      <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
      wd_q       <= '0;
      rdy_q      <= 1'b0;
      val_q      <= 1'b0;
      cerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      core_sel_q <= core_sel_d;
      core_rst_q <= core_rst_d;
      rcnt_q     <= rcnt_d;
      buf_q      <= buf_d;
      widx_q     <= widx_d;
      full_q     <= full_d;
      pend_q     <= pend_d;
      cbv_q      <= cbv_d;
      msg_q      <= msg_d;
      result_q   <= result_d;
      done_q     <= done_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
      wd_q       <= wd_d;
      rdy_q      <= core_block_ready;
      val_q      <= core_valid;
      cerr_q     <= core_error;
    end
  end

endmodule

// File: tb/tb_eddsa_block_ctrl.sv
// Directed-sequence bench with random data for eddsa_block_ctrl; expected blocks are
// assembled from the word stream by a simple packing model.
module tb_eddsa_block_ctrl;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_start = 1'b0, cmd_abort = 1'b0;
  logic [1:0]    cmd_sel = 2'd0;
  logic [63:0]   word_in = '0;
  logic          word_valid = 1'b0, word_last = 1'b0;
  logic          core_block_ready = 1'b0, core_valid = 1'b0, core_error = 1'b0;
  logic [511:0]  core_sig_pub = '0;

  logic          word_ready, core_rst, busy, done, err, timeout;
  logic [1:0]    core_sel, core_block_valid;
  logic [1023:0] core_message;
  logic [511:0]  result;

  logic          t_word_ready, t_core_rst, t_busy, t_done, t_err, t_timeout;
  logic [1:0]    t_core_sel, t_core_block_valid;
  logic [1023:0] t_core_message;
  logic [511:0]  t_result;

  always #5 clk = ~clk;

  eddsa_block_ctrl dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_sel(cmd_sel), .cmd_abort(cmd_abort),
    .word_in(word_in), .word_valid(word_valid), .word_last(word_last),
    .word_ready(word_ready), .core_rst(core_rst), .core_sel(core_sel),
    .core_message(core_message), .core_block_valid(core_block_valid),
    .core_block_ready(core_block_ready), .core_valid(core_valid), .core_error(core_error),
    .core_sig_pub(core_sig_pub), .busy(busy), .done(done), .err(err), .timeout(timeout),
    .result(result)
  );

  eddsa_block_ctrl #(.TIMEOUT(64)) dut_to (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_sel(cmd_sel), .cmd_abort(cmd_abort),
    .word_in(word_in), .word_valid(word_valid), .word_last(word_last),
    .word_ready(t_word_ready), .core_rst(t_core_rst), .core_sel(t_core_sel),
    .core_message(t_core_message), .core_block_valid(t_core_block_valid),
    .core_block_ready(core_block_ready), .core_valid(core_valid), .core_error(core_error),
    .core_sig_pub(core_sig_pub), .busy(t_busy), .done(t_done), .err(t_err),
    .timeout(t_timeout), .result(t_result)
  );

  int unsigned   n_pass = 0, n_total = 0;
  logic [1023:0] exp_blk = '0;
  int            wcount = 0;
  logic [63:0]   first_word;
  logic [511:0]  sig, sig2;
  int            n, c;
  logic          seen_done;
  logic [1:0]    cbv_seq [3] = '{2'b10, 2'b01, 2'b10};

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] req);
    int j;
    n_total++;
    assert (obs === req) n_pass++;
    else begin
      j = 0;
      for (int k = 15; k >= 0; k--) if (obs[64*k +: 64] !== req[64*k +: 64]) j = k;
      $error("FAIL %s: word %0d observed %h required %h", tag, j, obs[64*j +: 64],
             req[64*j +: 64]);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic req);
    chk(tag, 1024'(obs), 1024'(req));
  endtask

  task automatic chki(input string tag, input int obs, input int req);
    chk(tag, 1024'(obs), 1024'(req));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string pfx);
    chk1({pfx, "_busy"}, busy, 1'b0);
    chk1({pfx, "_done"}, done, 1'b0);
    chk1({pfx, "_err"}, err, 1'b0);
    chk1({pfx, "_timeout"}, timeout, 1'b0);
    chk1({pfx, "_word_ready"}, word_ready, 1'b0);
    chk1({pfx, "_core_rst"}, core_rst, 1'b0);
    chk({pfx, "_cbv"}, 1024'(core_block_valid), 1024'(2'b00));
    chk({pfx, "_core_sel"}, 1024'(core_sel), 1024'(2'b00));
    chk({pfx, "_message"}, core_message, '0);
    chk({pfx, "_result"}, 1024'(result), '0);
  endtask

  // Pulse cmd_start, then expect exactly RST_CYCLES (2) cycles of core_rst before RUN.
  task automatic start_op(input logic [1:0] sel);
    int cnt;
    cmd_start = 1'b1;
    cmd_sel   = sel;
    step();
    cmd_start = 1'b0;
    chk("start_core_sel", 1024'(core_sel), 1024'(sel));
    chk1("start_busy", busy, 1'b1);
    cnt = 0;
    while (core_rst === 1'b1 && cnt < 20) begin
      cnt++;
      step();
    end
    chki("start_core_rst_len", cnt, 2);
    chk1("start_run_ready", word_ready, 1'b1);
  endtask

  task automatic feed(input int nw, input bit last);
    logic [63:0] w;
    int b;
    for (int i = 0; i < nw; i++) begin
      repeat ($urandom_range(0, 2)) step();
      w = {$urandom, $urandom};
      b = 0;
      while (word_ready !== 1'b1 && b < 50) begin
        step();
        b++;
      end
      word_valid = 1'b1;
      word_in    = w;
      word_last  = last && (i == nw - 1);
      step();
      word_valid = 1'b0;
      word_last  = 1'b0;
      if (wcount == 0) first_word = w;
      exp_blk = exp_blk | (1024'(w) << (64 * (15 - wcount)));
      wcount++;
    end
  endtask

  task automatic new_blk();
    exp_blk = '0;
    wcount  = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b1;
    step();

    // Sign: three full blocks, each handed over when the core asks.
    start_op(2'd1);
    for (int b = 0; b < 3; b++) begin
      feed(16, 1'b0);
      chk1("sign_full_blocks_ready", word_ready, 1'b0);
      core_block_ready = 1'b1;
      step();
      core_block_ready = 1'b0;
      chk("sign_cbv", 1024'(core_block_valid), 1024'(cbv_seq[b]));
      chk("sign_message", core_message, exp_blk);
      new_blk();
      if (b == 0) begin
        cmd_start = 1'b1;
        cmd_sel   = 2'd3;
        step();
        cmd_start = 1'b0;
        chk("start_ignored_sel", 1024'(core_sel), 1024'(2'd1));
        chk1("start_ignored_rst", core_rst, 1'b0);
      end
    end
    for (int k = 0; k < 16; k++) sig[32*k +: 32] = $urandom;
    core_sig_pub = sig;
    core_valid   = 1'b1;
    step();
    core_valid = 1'b0;
    chk1("sign_done", done, 1'b1);
    chk("sign_result", 1024'(result), 1024'(sig));
    chk1("sign_idle", busy, 1'b0);
    step();
    chk1("sign_done_once", done, 1'b0);

    // Short block closed by word_last.
    start_op(2'd2);
    feed(10, 1'b1);
    chk1("short_full", word_ready, 1'b0);
    core_block_ready = 1'b1;
    step();
    core_block_ready = 1'b0;
    chk("short_cbv", 1024'(core_block_valid), 1024'(2'b10));
    chk("short_message", core_message, exp_blk);
    chk("short_low_zero", 1024'(core_message[383:0]), '0);
    chk("short_word0", 1024'(core_message[1023:960]), 1024'(first_word));
    new_blk();

    // Stall: request arrives with 5 words buffered.
    feed(5, 1'b0);
    core_block_ready = 1'b1;
    step();
    core_block_ready = 1'b0;
    chk("stall_hold_a", 1024'(core_block_valid), 1024'(2'b10));
    step();
    chk("stall_hold_b", 1024'(core_block_valid), 1024'(2'b10));
    feed(11, 1'b0);
    chk("stall_hold_full", 1024'(core_block_valid), 1024'(2'b10));
    step();
    chk("stall_toggle", 1024'(core_block_valid), 1024'(2'b01));
    chk("stall_message", core_message, exp_blk);
    new_blk();

    // Core error keeps the previous result.
    core_error = 1'b1;
    step();
    core_error = 1'b0;
    chk1("error_err", err, 1'b1);
    chk1("error_done", done, 1'b1);
    chk1("error_idle", busy, 1'b0);
    chk("error_result_kept", 1024'(result), 1024'(sig));
    step();
    chk1("error_done_once", done, 1'b0);

    // Abort wins over a simultaneous core_valid.
    start_op(2'd3);
    chk1("abort_err_cleared", err, 1'b0);
    feed(3, 1'b0);
    new_blk();
    for (int k = 0; k < 16; k++) sig2[32*k +: 32] = $urandom;
    core_sig_pub = sig2;
    cmd_abort    = 1'b1;
    core_valid   = 1'b1;
    step();
    cmd_abort  = 1'b0;
    core_valid = 1'b0;
    chk1("abort_no_done", done, 1'b0);
    chk1("abort_idle", busy, 1'b0);
    chk("abort_result_kept", 1024'(result), 1024'(sig));
    seen_done = 1'b0;
    c = 0;
    while (core_rst === 1'b1 && c < 20) begin
      c++;
      if (done === 1'b1) seen_done = 1'b1;
      step();
    end
    chki("abort_core_rst_len", c, 2);
    chk1("abort_never_done", seen_done, 1'b0);

    // Asynchronous reset in the middle of RUN.
    start_op(2'd1);
    feed(4, 1'b0);
    new_blk();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_reset("midrun");
    step();
    step();
    rst = 1'b1;
    step();

    // Watchdog on the TIMEOUT=64 instance.
    start_op(2'd1);
    n = 0;
    while (t_done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chki("timeout_cycles", n, 64);
    chk1("timeout_flag", t_timeout, 1'b1);
    chk1("timeout_err", t_err, 1'b1);
    chk1("timeout_idle", t_busy, 1'b0);
    chk1("timeout_core_rst_a", t_core_rst, 1'b1);
    chk1("timeout_long_busy", busy, 1'b1);
    step();
    chk1("timeout_done_once", t_done, 1'b0);
    chk1("timeout_core_rst_b", t_core_rst, 1'b1);
    step();
    chk1("timeout_core_rst_end", t_core_rst, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
